// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Generic Y86-64 inter-stage pipeline register (F->D, D->E, E->M, M->W).
//   Captures the instruction fields and status code every rising edge, under
//   control of stall (hold) and bubble (insert a nop). It also tracks whether
//   the slot carries a real instruction, keeps saturating counts of stall
//   cycles and injected bubbles, and raises a sticky error when stall and
//   bubble arrive together.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   stall, bubble        pipeline control from the hazard unit
//   in_stat..in_valP     upstream instruction fields
//   out_stat..out_valP   registered instruction fields (1-cycle latency)
//   out_valid            1 = slot holds a real instruction, 0 = bubble
//   stall_cnt            stalled cycles, saturating
//   bubble_cnt           injected bubbles, saturating
//   ctl_err              sticky flag: stall and bubble seen together
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                WORD_W       = 64,
  parameter int                NIB_W        = 4,
  parameter int                STAT_W       = 3,
  parameter int                CNT_W        = 16,
  parameter logic [NIB_W-1:0]  BUBBLE_ICODE = 'h1,
  parameter logic [NIB_W-1:0]  RNONE        = 'hF,
  parameter logic [STAT_W-1:0] STAT_AOK     = 'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              bubble,
  input  logic [STAT_W-1:0] in_stat,
  input  logic [NIB_W-1:0]  in_icode,
  input  logic [NIB_W-1:0]  in_ifun,
  input  logic [NIB_W-1:0]  in_rA,
  input  logic [NIB_W-1:0]  in_rB,
  input  logic [WORD_W-1:0] in_valC,
  input  logic [WORD_W-1:0] in_valP,
  output logic [STAT_W-1:0] out_stat,
  output logic [NIB_W-1:0]  out_icode,
  output logic [NIB_W-1:0]  out_ifun,
  output logic [NIB_W-1:0]  out_rA,
  output logic [NIB_W-1:0]  out_rB,
  output logic [WORD_W-1:0] out_valC,
  output logic [WORD_W-1:0] out_valP,
  output logic              out_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic              ctl_err
);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [STAT_W-1:0] stat_p1;
  logic [NIB_W-1:0]  icode_p1;
  logic [NIB_W-1:0]  ifun_p1;
  logic [NIB_W-1:0]  ra_p1;
  logic [NIB_W-1:0]  rb_p1;
  logic [WORD_W-1:0] valc_p1;
  logic [WORD_W-1:0] valp_p1;
  logic              vld_p1;
  logic [CNT_W-1:0]  stall_cnt_p1;
  logic [CNT_W-1:0]  bubble_cnt_p1;
  logic              ctl_err_p1;

  // ---- stage boundary: upstream inputs -> registered slot (_p1) ----
  // Reset and bubble both leave the slot holding an INOP, so the downstream
  // stage sees a harmless instruction either way. Stall outranks bubble, which
  // is why the illegal stall+bubble case simply holds and flags the error.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_p1       <= STAT_AOK;
      icode_p1      <= BUBBLE_ICODE;
      ifun_p1       <= '0;
      ra_p1         <= RNONE;
      rb_p1         <= RNONE;
      valc_p1       <= '0;
      valp_p1       <= '0;
      vld_p1        <= 1'b0;
      stall_cnt_p1  <= '0;
      bubble_cnt_p1 <= '0;
      ctl_err_p1    <= 1'b0;
    end else if (stall) begin
      stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      if (bubble) begin
        ctl_err_p1 <= 1'b1;
      end
    end else if (bubble) begin
      stat_p1       <= STAT_AOK;
      icode_p1      <= BUBBLE_ICODE;
      ifun_p1       <= '0;
      ra_p1         <= RNONE;
      rb_p1         <= RNONE;
      valc_p1       <= '0;
      valp_p1       <= '0;
      vld_p1        <= 1'b0;
      bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
    end else begin
      stat_p1  <= in_stat;
      icode_p1 <= in_icode;
      ifun_p1  <= in_ifun;
      ra_p1    <= in_rA;
      rb_p1    <= in_rB;
      valc_p1  <= in_valC;
      valp_p1  <= in_valP;
      vld_p1   <= 1'b1;
    end
  end

  assign out_stat   = stat_p1;
  assign out_icode  = icode_p1;
  assign out_ifun   = ifun_p1;
  assign out_rA     = ra_p1;
  assign out_rB     = rb_p1;
  assign out_valC   = valc_p1;
  assign out_valP   = valp_p1;
  assign out_valid  = vld_p1;
  assign stall_cnt  = stall_cnt_p1;
  assign bubble_cnt = bubble_cnt_p1;
  assign ctl_err    = ctl_err_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg. A default-width instance and a second
//   instance with CNT_W=4 share the same stimulus; the narrow one exposes
//   counter saturation within a short run.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, stall, bubble;
  logic [2:0]  in_stat;
  logic [3:0]  in_icode, in_ifun, in_rA, in_rB;
  logic [63:0] in_valC, in_valP;

  logic [2:0]  out_stat;
  logic [3:0]  out_icode, out_ifun, out_rA, out_rB;
  logic [63:0] out_valC, out_valP;
  logic        out_valid, ctl_err;
  logic [15:0] stall_cnt, bubble_cnt;

  logic [2:0]  s_stat;
  logic [3:0]  s_icode, s_ifun, s_rA, s_rB;
  logic [63:0] s_valC, s_valP;
  logic        s_valid, s_err;
  logic [3:0]  s_stall_cnt, s_bubble_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_rA(in_rA), .in_rB(in_rB), .in_valC(in_valC), .in_valP(in_valP),
    .out_stat(out_stat), .out_icode(out_icode), .out_ifun(out_ifun),
    .out_rA(out_rA), .out_rB(out_rB), .out_valC(out_valC), .out_valP(out_valP),
    .out_valid(out_valid), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
    .ctl_err(ctl_err)
  );

  pipe_stage_reg #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_rA(in_rA), .in_rB(in_rB), .in_valC(in_valC), .in_valP(in_valP),
    .out_stat(s_stat), .out_icode(s_icode), .out_ifun(s_ifun),
    .out_rA(s_rA), .out_rB(s_rB), .out_valC(s_valC), .out_valP(s_valP),
    .out_valid(s_valid), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt),
    .ctl_err(s_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vc, input logic [63:0] vp);
    in_stat  = st;
    in_icode = ic;
    in_ifun  = fn;
    in_rA    = ra;
    in_rB    = rb;
    in_valC  = vc;
    in_valP  = vp;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; bubble = 1'b0;
    drive(3'd0, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0);
    tick();

    // Reset state
    check("rst_icode",  64'(out_icode),  64'h1);
    check("rst_ifun",   64'(out_ifun),   64'h0);
    check("rst_rA",     64'(out_rA),     64'hF);
    check("rst_rB",     64'(out_rB),     64'hF);
    check("rst_stat",   64'(out_stat),   64'h1);
    check("rst_valC",   out_valC,        64'h0);
    check("rst_valP",   out_valP,        64'h0);
    check("rst_valid",  64'(out_valid),  64'h0);
    check("rst_scnt",   64'(stall_cnt),  64'h0);
    check("rst_bcnt",   64'(bubble_cnt), 64'h0);
    check("rst_err",    64'(ctl_err),    64'h0);

    // Test 1: plain load
    rst = 1'b0;
    drive(3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h102);
    tick();
    check("ld_icode", 64'(out_icode), 64'h6);
    check("ld_ifun",  64'(out_ifun),  64'h0);
    check("ld_rA",    64'(out_rA),    64'h2);
    check("ld_rB",    64'(out_rB),    64'h3);
    check("ld_valC",  out_valC,       64'h0);
    check("ld_valP",  out_valP,       64'h102);
    check("ld_stat",  64'(out_stat),  64'h1);
    check("ld_valid", 64'(out_valid), 64'h1);

    // Test 2: stall 3 cycles with changing inputs
    stall = 1'b1;
    drive(3'd2, 4'h3, 4'h1, 4'h5, 4'h7, 64'h55, 64'h200);
    tick();
    drive(3'd3, 4'h7, 4'h4, 4'h9, 4'hA, 64'h66, 64'h300);
    tick();
    drive(3'd4, 4'h8, 4'h2, 4'h1, 4'h0, 64'h77, 64'h400);
    tick();
    check("stl_icode", 64'(out_icode), 64'h6);
    check("stl_rA",    64'(out_rA),    64'h2);
    check("stl_rB",    64'(out_rB),    64'h3);
    check("stl_valC",  out_valC,       64'h0);
    check("stl_valP",  out_valP,       64'h102);
    check("stl_stat",  64'(out_stat),  64'h1);
    check("stl_valid", 64'(out_valid), 64'h1);
    check("stl_scnt",  64'(stall_cnt), 64'h3);
    check("stl_bcnt",  64'(bubble_cnt), 64'h0);

    // Test 3: one bubble
    stall = 1'b0; bubble = 1'b1;
    tick();
    check("bub_icode", 64'(out_icode),  64'h1);
    check("bub_ifun",  64'(out_ifun),   64'h0);
    check("bub_rA",    64'(out_rA),     64'hF);
    check("bub_rB",    64'(out_rB),     64'hF);
    check("bub_valC",  out_valC,        64'h0);
    check("bub_valP",  out_valP,        64'h0);
    check("bub_stat",  64'(out_stat),   64'h1);
    check("bub_valid", 64'(out_valid),  64'h0);
    check("bub_bcnt",  64'(bubble_cnt), 64'h1);
    check("bub_scnt",  64'(stall_cnt),  64'h3);

    // Reload a fresh vector before the illegal-control test
    bubble = 1'b0;
    drive(3'd2, 4'h2, 4'h5, 4'h7, 4'hF, 64'hDEADBEEF_00000010, 64'h10A);
    tick();
    check("ld2_icode", 64'(out_icode), 64'h2);
    check("ld2_ifun",  64'(out_ifun),  64'h5);
    check("ld2_valC",  out_valC,       64'hDEADBEEF_00000010);
    check("ld2_stat",  64'(out_stat),  64'h2);
    check("ld2_valid", 64'(out_valid), 64'h1);

    // Test 4: stall and bubble together
    stall = 1'b1; bubble = 1'b1;
    drive(3'd1, 4'hA, 4'h0, 4'h4, 4'h4, 64'h1234, 64'h5678);
    tick();
    check("sb_icode", 64'(out_icode),  64'h2);
    check("sb_valC",  out_valC,        64'hDEADBEEF_00000010);
    check("sb_valP",  out_valP,        64'h10A);
    check("sb_valid", 64'(out_valid),  64'h1);
    check("sb_err",   64'(ctl_err),    64'h1);
    check("sb_bcnt",  64'(bubble_cnt), 64'h1);
    check("sb_scnt",  64'(stall_cnt),  64'h4);

    stall = 1'b0; bubble = 1'b0;
    tick();
    check("sb_sticky", 64'(ctl_err),   64'h1);
    check("sb_load",   64'(out_icode), 64'hA);
    check("sb_loadP",  out_valP,       64'h5678);

    rst = 1'b1;
    tick();
    check("sb_clr_err",  64'(ctl_err),    64'h0);
    check("sb_clr_scnt", 64'(stall_cnt),  64'h0);
    check("sb_clr_bcnt", 64'(bubble_cnt), 64'h0);

    // Test 6: reset together with stall
    rst = 1'b0;
    drive(3'd1, 4'h5, 4'h3, 4'h1, 4'h2, 64'h99, 64'hABC);
    tick();
    check("pre6_icode", 64'(out_icode), 64'h5);
    stall = 1'b1;
    tick();
    check("pre6_scnt", 64'(stall_cnt), 64'h1);
    rst = 1'b1;
    tick();
    check("rs_icode", 64'(out_icode),  64'h1);
    check("rs_rA",    64'(out_rA),     64'hF);
    check("rs_valP",  out_valP,        64'h0);
    check("rs_valid", 64'(out_valid),  64'h0);
    check("rs_scnt",  64'(stall_cnt),  64'h0);
    check("rs_bcnt",  64'(bubble_cnt), 64'h0);

    // Test 5: saturation of a 4-bit counter over a 20-cycle stall
    rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("sat_s15",   64'(s_stall_cnt), 64'hF);
    for (int i = 0; i < 5; i++) tick();
    check("sat_s20",   64'(s_stall_cnt), 64'hF);
    check("sat_wide",  64'(stall_cnt),   64'd20);
    check("sat_hold",  64'(s_icode),     64'h1);

    // Bubble counter saturation on the narrow instance
    stall = 1'b0; bubble = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    check("satb_small", 64'(s_bubble_cnt), 64'hF);
    check("satb_wide",  64'(bubble_cnt),   64'd18);
    check("satb_valid", 64'(s_valid),      64'h0);
    check("satb_err",   64'(s_err),        64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
